wfg_axis_arb: RTL



---
 rtl/wfg_axis_arb_pkg.sv | 14 +
 rtl/wfg_rr_picker.sv | 33 +++
 rtl/wfg_axis_arb.sv | 96 +++++++++
 3 files changed

// File: rtl/wfg_axis_arb_pkg.sv
// Shared types and helpers for the waveform-generator AXI-Stream arbiter.
package wfg_axis_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int gnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wfg_rr_picker.sv
// Combinational round-robin picker: searches upward from last+1 with wrap.
module wfg_rr_picker
  import wfg_axis_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = gnt_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  always_comb begin
    int         idx;
    logic [W-1:0] idx_w;
    logic       found;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int k = 1; k <= N; k++) begin
      idx   = (int'(last) + k) % N;
      idx_w = W'(idx);
      if (!found && req[idx_w]) begin
        found   = 1'b1;
        gnt_idx = idx_w;
      end
    end
    any = found;
  end

endmodule

// File: rtl/wfg_axis_arb.sv
// Packet-locked round-robin AXI-Stream arbiter feeding the pattern driver.
module wfg_axis_arb
  import wfg_axis_arb_pkg::*;
#(
  parameter int NUM_SRC         = 4,
  parameter int AXIS_DATA_WIDTH = 32,
  localparam int GW             = gnt_w(NUM_SRC)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_SRC-1:0]                       src_en_i,
  input  logic [NUM_SRC-1:0]                       s_axis_tvalid_i,
  input  logic [NUM_SRC-1:0][AXIS_DATA_WIDTH-1:0]  s_axis_tdata_i,
  input  logic [NUM_SRC-1:0]                       s_axis_tlast_i,
  output logic [NUM_SRC-1:0]                       s_axis_tready_o,
  output logic                                     m_axis_tvalid_o,
  output logic [AXIS_DATA_WIDTH-1:0]               m_axis_tdata_o,
  output logic                                     m_axis_tlast_o,
  input  logic                                     m_axis_tready_i,
  output logic [GW-1:0]                            grant_o,
  output logic                                     busy_o
);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] pick_idx;
  logic          pick_any;
  logic          locked;
  logic          eop;

  wfg_rr_picker #(.N(NUM_SRC), .W(GW)) u_picker (
    .req     (src_en_i & s_axis_tvalid_i),
    .last    (last_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign locked = (state_q == LOCKED);

  // Pure pass-through of the locked source; nothing is buffered here.
  always_comb begin
    m_axis_tvalid_o = 1'b0;
    m_axis_tdata_o  = '0;
    m_axis_tlast_o  = 1'b0;
    if (locked) begin
      m_axis_tvalid_o = s_axis_tvalid_i[grant_q];
      m_axis_tdata_o  = s_axis_tdata_i[grant_q];
      m_axis_tlast_o  = s_axis_tlast_i[grant_q];
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_rdy
    assign s_axis_tready_o[i] = locked && (grant_q == GW'(i)) && m_axis_tready_i;
  end

  assign eop = m_axis_tvalid_o & m_axis_tready_i & m_axis_tlast_o;

  // src_en_i only gates new grants; an open packet always runs to tlast.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = LOCKED;
          grant_d = pick_idx;
        end
      end
      LOCKED: begin
        if (eop) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_SRC - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = locked;

endmodule
